conv_stream_engine: RTL

CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

---
 rtl/conv_stream_engine.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming KxK convolution over an NxN raster-order frame.
// One pixel is accepted per cycle while ce is high. Each completed stride-aligned
// window produces one signed, saturated result two cycles after its last pixel.
// Optional build macro CONV_RELU_EN: negative saturated results are output as 0.

module conv_stream_engine #(
  parameter int N  = 10,
  parameter int K  = 3,
  parameter int S  = 1,
  parameter int DW = 16,
  parameter int OW = 32
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              ce,
  input  logic [K*K*DW-1:0] weight,
  input  logic [DW-1:0]     activation,
  output logic [OW-1:0]     data_out,
  output logic              valid_op,
  output logic              end_op
);

  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int KK   = K * K;
  localparam int SW   = 2 * DW + $clog2(KK);
  localparam int XW   = (SW > OW) ? SW : OW;
  // Newest pixel at tap 0; the oldest window pixel sits (K-1) rows plus (K-1) columns back.
  localparam int TAPS = (K - 1) * N + K;

  localparam logic [CW-1:0]        LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0]        ZERO_IDX = {CW{1'b0}};
  localparam logic [CW-1:0]        ONE_IDX  = CW'(1);
  localparam logic [31:0]          KM1      = 32'(K - 1);
  localparam logic [31:0]          STRIDE   = 32'(S);
  localparam logic signed [OW-1:0] MAX_OW   = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MIN_OW   = {1'b1, {(OW-1){1'b0}}};

  logic [CW-1:0]          row_r;
  logic [CW-1:0]          col_r;
  logic [K*K*DW-1:0]      weight_r;
  logic [DW-1:0]          taps_r [TAPS];
  logic [DW-1:0]          win_s  [KK];
  logic [31:0]            row_w_s;
  logic [31:0]            col_w_s;
  logic                   win_done_s;
  logic                   frame_last_s;
  logic                   first_px_s;
  logic                   v0_r;
  logic                   e0_r;
  logic                   v1_r;
  logic                   e1_r;
  logic signed [2*DW-1:0] prod_r [KK];
  logic signed [SW-1:0]   sum_s;
  logic signed [XW-1:0]   sum_x_s;
  logic [OW-1:0]          sat_s;
  logic [OW-1:0]          res_s;

  // Window element i = row*K+col (row 0 oldest) taken from fixed taps of the shift chain.
  for (genvar a = 0; a < K; a++) begin : g_row
    for (genvar b = 0; b < K; b++) begin : g_col
      assign win_s[a*K+b] = taps_r[(K-1-a)*N + (K-1-b)];
    end
  end

  // Decode the position of the pixel being offered: frame start, frame end, window completion.
  always_comb begin
    row_w_s      = 32'(row_r);
    col_w_s      = 32'(col_r);
    first_px_s   = (row_r == ZERO_IDX) && (col_r == ZERO_IDX);
    frame_last_s = (row_r == LAST_IDX) && (col_r == LAST_IDX);
    if ((row_w_s >= KM1) && (col_w_s >= KM1) &&
        (((row_w_s - KM1) % STRIDE) == 32'd0) &&
        (((col_w_s - KM1) % STRIDE) == 32'd0)) begin
      win_done_s = 1'b1;
    end else begin
      win_done_s = 1'b0;
    end
  end

  // Raster position counters and per-frame weight latch, advancing only on accepted pixels.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      row_r    <= ZERO_IDX;
      col_r    <= ZERO_IDX;
      weight_r <= {(K*K*DW){1'b0}};
    end else if (ce) begin
      if (first_px_s) begin
        weight_r <= weight;
      end
      if (col_r == LAST_IDX) begin
        col_r <= ZERO_IDX;
        if (row_r == LAST_IDX) begin
          row_r <= ZERO_IDX;
        end else begin
          row_r <= row_r + ONE_IDX;
        end
      end else begin
        col_r <= col_r + ONE_IDX;
      end
    end
  end

  // Line buffers and window register as one shift chain; contents need no reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      taps_r[0] <= activation;
      for (int t = 1; t < TAPS; t++) begin
        taps_r[t] <= taps_r[t-1];
      end
    end
  end

  // Stage 1: multiply the just-completed window by the frame's latched weights.
  always_ff @(posedge clk) begin
    if (v0_r) begin
      for (int i = 0; i < KK; i++) begin
        prod_r[i] <= $signed(weight_r[DW*i +: DW]) * $signed(win_s[i]);
      end
    end
  end

  // Full-precision sum of the registered products.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < KK; i++) begin
      sum_s = sum_s + SW'(prod_r[i]);
    end
  end

  // Clamp the full-precision sum into the signed output range.
  always_comb begin
    sum_x_s = XW'(sum_s);
    if (sum_x_s > XW'(MAX_OW)) begin
      sat_s = MAX_OW;
    end else if (sum_x_s < XW'(MIN_OW)) begin
      sat_s = MIN_OW;
    end else begin
      sat_s = sum_x_s[OW-1:0];
    end
  end

  // Optional rectification of the saturated result; timing is identical in both builds.
  always_comb begin
`ifdef CONV_RELU_EN
    if (sat_s[OW-1]) begin
      res_s = {OW{1'b0}};
    end else begin
      res_s = sat_s;
    end
`else
    res_s = sat_s;
`endif
  end

  // Valid/end pipeline and registered outputs; data_out holds between results.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      v0_r     <= 1'b0;
      e0_r     <= 1'b0;
      v1_r     <= 1'b0;
      e1_r     <= 1'b0;
      valid_op <= 1'b0;
      end_op   <= 1'b0;
      data_out <= {OW{1'b0}};
    end else begin
      v0_r     <= ce & win_done_s;
      e0_r     <= ce & win_done_s & frame_last_s;
      v1_r     <= v0_r;
      e1_r     <= e0_r;
      valid_op <= v1_r;
      end_op   <= e1_r;
      if (v1_r) begin
        data_out <= res_s;
      end
    end
  end

endmodule
